// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the register-file read ports, the
// multiply/divide unit and the writeback mux. data_remainder exists only with MULTDIV_REMAINDER_EN.
interface multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
        , input data_remainder
`endif
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
        , output data_remainder
`endif
    );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes), fixed WIDTH-cycle
// latency. Optional remainder output enabled by defining MULTDIV_REMAINDER_EN.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic      clock,
    input logic      ctrl_reset,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             is_div_q, is_div_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;
    logic             div_ovf_q, div_ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic             start, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, mul_hi, div_shift, div_diff, div_hi;
    logic [WIDTH-1:0] mul_lo, div_lo;
    logic             mul_ovf;

    assign start  = bus.ctrl_MULT ^ bus.ctrl_DIV;
    assign sign_a = bus.data_operandA[WIDTH-1];
    assign sign_b = bus.data_operandB[WIDTH-1];
    assign mag_a  = sign_a ? -bus.data_operandA : bus.data_operandA;
    assign mag_b  = sign_b ? -bus.data_operandB : bus.data_operandB;

    // One iteration of each algorithm; the accumulator is WIDTH+1 bits so Booth survives INT_MIN.
    always_comb begin
        mul_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   mul_sum = hi_q + {opd_q[WIDTH-1], opd_q};
            2'b10:   mul_sum = hi_q - {opd_q[WIDTH-1], opd_q};
            default: mul_sum = hi_q;
        endcase
        mul_hi    = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
        mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
        mul_ovf   = !((&{mul_hi[WIDTH-1:0], mul_lo[WIDTH-1]}) ||
                      !(|{mul_hi[WIDTH-1:0], mul_lo[WIDTH-1]}));
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_hi    = div_diff[WIDTH] ? div_shift : div_diff;
        div_lo    = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        qm1_d      = qm1_q;
        opd_d      = opd_q;
        is_div_d   = is_div_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        result_d   = result_q;
        exc_d      = exc_q;
`ifdef MULTDIV_REMAINDER_EN
        rem_d      = rem_q;
`endif
        if (start) begin
            state_d    = StBusy;
            cnt_d      = '0;
            is_div_d   = bus.ctrl_DIV;
            hi_d       = '0;
            qm1_d      = 1'b0;
            opd_d      = bus.ctrl_DIV ? mag_b : bus.data_operandA;
            lo_d       = bus.ctrl_DIV ? mag_a : bus.data_operandB;
            q_neg_d    = sign_a ^ sign_b;
            r_neg_d    = sign_a;
            div_zero_d = (bus.data_operandB == '0);
            div_ovf_d  = (bus.data_operandA == IntMin) && (bus.data_operandB == '1);
        end else begin
            case (state_q)
                StBusy: begin
                    cnt_d = cnt_q + 1'b1;
                    hi_d  = is_div_q ? div_hi : mul_hi;
                    lo_d  = is_div_q ? div_lo : mul_lo;
                    qm1_d = lo_q[0];
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StDone;
`ifdef MULTDIV_REMAINDER_EN
                        rem_d   = '0;
`endif
                        if (!is_div_q) begin
                            result_d = mul_lo;
                            exc_d    = mul_ovf;
                        end else if (div_zero_q) begin
                            result_d = '0;
                            exc_d    = 1'b1;
                        end else if (div_ovf_q) begin
                            result_d = IntMin;
                            exc_d    = 1'b1;
                        end else begin
                            result_d = q_neg_q ? -div_lo : div_lo;
                            exc_d    = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
                            rem_d    = r_neg_q ? -div_hi[WIDTH-1:0] : div_hi[WIDTH-1:0];
`endif
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            qm1_q      <= 1'b0;
            opd_q      <= '0;
            is_div_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            rem_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            qm1_q      <= qm1_d;
            opd_q      <= opd_d;
            is_div_q   <= is_div_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            div_ovf_q  <= div_ovf_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
`ifdef MULTDIV_REMAINDER_EN
            rem_q      <= rem_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == StDone);
    assign bus.busy           = (state_q == StBusy);
`ifdef MULTDIV_REMAINDER_EN
    assign bus.data_remainder = rem_q;
`endif
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: arithmetic reference model checked every cycle, plus directed
// vectors with literal expectations. Remainder checks only when MULTDIV_REMAINDER_EN is defined.
module tb_multdiv_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    multdiv_if #(.WIDTH(W)) bus ();
    multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int rdy_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void ref_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e, output logic [31:0] rm);
        longint p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        rm = '0;
        if (!is_div) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r  = sa / sb;
            rm = sa % sb;
            e  = 1'b0;
        end
    endfunction

    logic        model_ok = 1'b0;
    int          remaining = 0;
    logic        exp_busy = 1'b0, exp_rdy = 1'b0, exp_exc = 1'b0, pend_exc = 1'b0;
    logic [31:0] exp_res = '0, pend_res = '0, exp_rem = '0, pend_rem = '0;

    always @(posedge clock) begin
        if (ctrl_reset) begin
            model_ok  = 1'b1;
            remaining = 0;
            exp_busy  = 1'b0;
            exp_rdy   = 1'b0;
            exp_res   = '0;
            exp_exc   = 1'b0;
            exp_rem   = '0;
        end else begin
            exp_rdy = 1'b0;
            if (bus.ctrl_MULT ^ bus.ctrl_DIV) begin
                ref_op(bus.ctrl_DIV, bus.data_operandA, bus.data_operandB,
                       pend_res, pend_exc, pend_rem);
                remaining = W;
                exp_busy  = 1'b1;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_busy = 1'b0;
                    exp_rdy  = 1'b1;
                    exp_res  = pend_res;
                    exp_exc  = pend_exc;
                    exp_rem  = pend_rem;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("resultRDY", 32'(bus.data_resultRDY), 32'(exp_rdy));
            check("result", bus.data_result, exp_res);
            check("exception", 32'(bus.data_exception), 32'(exp_exc));
`ifdef MULTDIV_REMAINDER_EN
            check("remainder", bus.data_remainder, exp_rem);
`endif
            if (bus.data_resultRDY) rdy_seen++;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = !is_div;
        bus.ctrl_DIV      = is_div;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic run(input string name, input bit is_div, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc);
        int lat;
        pulse(is_div, a, b);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.data_resultRDY && lat < 40);
        check({name, "_latency"}, 32'(lat), 32'd32);
        check({name, "_result"}, bus.data_result, res);
        check({name, "_exception"}, 32'(bus.data_exception), 32'(exc));
    endtask

    initial begin
        int snap;
        ctrl_reset        = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) tick();
        check("reset_result", bus.data_result, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        ctrl_reset = 1'b0;
        tick();

        run("mul_7x-6", 1'b0, 32'd7, -32'sd6, 32'hFFFF_FFD6, 1'b0);
        tick();
        check("idle_after_done", 32'(bus.busy | bus.data_resultRDY), 32'd0);
        run("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run("div_-7/2", 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0);
`ifdef MULTDIV_REMAINDER_EN
        check("rem_-7/2", bus.data_remainder, 32'hFFFF_FFFF);
`endif
        run("div_by_zero", 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run("div_intmin", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run("mul_intmin_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
        run("mul_intmin_x1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run("mul_-1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run("div_-100/-7", 1'b1, -32'sd100, -32'sd7, 32'd14, 1'b0);
`ifdef MULTDIV_REMAINDER_EN
        check("rem_-100/-7", bus.data_remainder, 32'hFFFF_FFFE);
`endif
        run("div_7/-100", 1'b1, 32'd7, -32'sd100, 32'd0, 1'b0);

        // Restart mid-multiply: only the divide may strobe.
        snap = rdy_seen;
        pulse(1'b0, 32'd3, 32'd4);
        repeat (9) tick();
        run("abort_div", 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
        check("abort_strobes", 32'(rdy_seen - snap), 32'd1);

        pulse(1'b0, 32'h0000_1234, 32'd5);
        repeat (4) tick();
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_result", bus.data_result, 32'd0);
        check("midrst_exc", 32'(bus.data_exception), 32'd0);
        snap = rdy_seen;
        repeat (40) tick();
        check("midrst_no_rdy", 32'(rdy_seen - snap), 32'd0);

        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd3;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        tick();
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        check("both_busy", 32'(bus.busy), 32'd0);
        snap = rdy_seen;
        repeat (40) tick();
        check("both_no_rdy", 32'(rdy_seen - snap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
